user_spi_target: RTL and testbench

Synthesizable SPI target (responder) for the user SPI bus, i.e. the receiving end of the SoC's `user_spi_sck`/`user_spi_mosi`/chip-select outputs. It implements an ADXL345-style register protocol (mode 3, command byte then data bytes) over a 64×8 register file. A local port lets the host side inject sensor data or inspect writes. It is used for on-chip loopback of the user SPI master and as an accelerometer emulator in FPGA/bring-up builds. All SPI inputs are oversampled in the single system clock; there is no SCK clock domain.

---
 rtl/user_spi_pkg.sv | 17 +
 rtl/user_spi_sync.sv | 39 +++
 rtl/user_spi_target.sv | 196 +++++++++++++++++++
 tb/tb_user_spi_target.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/user_spi_pkg.sv
// Shared types and constants for the user SPI target: FSM states,
// command-byte field positions and register-file geometry.
package user_spi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCmd   = 2'd1,
    StWdata = 2'd2,
    StRdata = 2'd3
  } user_spi_state_e;

  localparam int unsigned CmdRnwBit    = 7;
  localparam int unsigned CmdMbBit     = 6;
  localparam int unsigned RegAddrWidth = 6;
  localparam logic [RegAddrWidth-1:0] DevIdAddr = 6'h00;

endpackage

// File: rtl/user_spi_sync.sv
// N-stage synchronizer with one extra register for rise/fall edge detection.
// ResetVal sets the idle level so reset never produces a spurious edge.
module user_spi_sync
  import user_spi_pkg::*;
#(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    prev_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/user_spi_target.sv
// SPI mode-3 target with an ADXL345-style command protocol over a 64x8
// register file; all SPI pins are oversampled in clk_i.
module user_spi_target
  import user_spi_pkg::*;
#(
  parameter logic [7:0]  DevId      = 8'hE5,
  parameter int unsigned SyncStages = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    spi_sck_i,
  input  logic                    spi_mosi_i,
  input  logic                    spi_cs_ni,
  output logic                    spi_miso_o,
  output logic                    spi_miso_oe_o,
  input  logic                    reg_we_i,
  input  logic [RegAddrWidth-1:0] reg_addr_i,
  input  logic [7:0]              reg_wdata_i,
  output logic [7:0]              reg_rdata_o,
  output logic                    spi_wr_o,
  output logic [RegAddrWidth-1:0] spi_wr_addr_o,
  output logic [7:0]              spi_wr_data_o,
  output logic                    busy_o
);

  localparam int unsigned NumRegs = 2 ** RegAddrWidth;

  logic sck_rise, sck_fall, sck_level_unused;
  logic mosi_q, mosi_rise_unused, mosi_fall_unused;
  logic cs_n_q, cs_fall, cs_rise_unused;

  // SCK idles high (CPOL=1) and CS idles deasserted, so both reset to 1.
  user_spi_sync #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_sck (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_sck_i),
    .q_o    (sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  user_spi_sync #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_mosi_i),
    .q_o    (mosi_q),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  user_spi_sync #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_cs_ni),
    .q_o    (cs_n_q),
    .rise_o (cs_rise_unused),
    .fall_o (cs_fall)
  );

  user_spi_state_e         state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [6:0]              rx_q, rx_d;
  logic                    mb_q, mb_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic [7:0]              tx_q, tx_d;
  logic                    miso_q, miso_d;
  logic                    wr_q, wr_d;
  logic [RegAddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic [7:0]              regs_q [NumRegs];
  logic [7:0]              regs_d [NumRegs];

  logic [7:0]              rx_byte;
  logic                    byte_done;
  logic [RegAddrWidth-1:0] next_addr;
  logic [RegAddrWidth-1:0] rd_addr;
  logic [7:0]              rd_data;

  always_comb begin
    rx_byte   = {rx_q, mosi_q};
    byte_done = sck_rise && (bit_cnt_q == 3'd7);
    next_addr = mb_q ? addr_q + RegAddrWidth'(1) : addr_q;
    // The shift register is loaded either from the freshly received command
    // address or from the next data address, depending on the phase.
    rd_addr   = (state_q == StCmd) ? rx_byte[RegAddrWidth-1:0] : next_addr;
    rd_data   = (rd_addr == DevIdAddr) ? DevId : regs_q[rd_addr];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    mb_d      = mb_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if ((state_q != StIdle) && cs_n_q) begin
      state_d = StIdle;
      miso_d  = 1'b0;
    end else begin
      if (sck_rise && (state_q != StIdle)) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      unique case (state_q)
        StIdle: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
          end
        end
        StCmd: begin
          if (byte_done) begin
            mb_d   = rx_byte[CmdMbBit];
            addr_d = rx_byte[RegAddrWidth-1:0];
            if (rx_byte[CmdRnwBit]) begin
              state_d = StRdata;
              tx_d    = rd_data;
            end else begin
              state_d = StWdata;
            end
          end
        end
        StWdata: begin
          if (byte_done) begin
            if (addr_q != DevIdAddr) begin
              wr_d      = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_byte;
            end
            addr_d = next_addr;
          end
        end
        StRdata: begin
          if (byte_done) begin
            addr_d = next_addr;
            tx_d   = rd_data;
          end else if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // The SPI commit is applied last so it overrides a same-address local write.
  always_comb begin
    regs_d = regs_q;
    if (reg_we_i && (reg_addr_i != DevIdAddr)) regs_d[reg_addr_i] = reg_wdata_i;
    if (wr_d) regs_d[wr_addr_d] = wr_data_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      mb_q      <= 1'b0;
      addr_q    <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      mb_q      <= mb_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q    <= regs_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = ~cs_n_q;
  assign reg_rdata_o   = regs_q[reg_addr_i];
  assign spi_wr_o      = wr_q;
  assign spi_wr_addr_o = wr_addr_q;
  assign spi_wr_data_o = wr_data_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_user_spi_target.sv
// Self-checking bench: a bit-banged SPI controller plus a register-file model
// that predicts read bytes, write pulses and local read-back every cycle.
module tb_user_spi_target;

  localparam int Half     = 5;
  localparam int CsSetup  = 5;
  localparam int CsHold   = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b1;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       we = 1'b0;
  logic [5:0] raddr = 6'h01;
  logic [7:0] wdata = 8'h00;
  logic       miso, oe, wr, busy;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, rdata;

  always #5 clk = ~clk;

  user_spi_target #(.DevId(8'hE5), .SyncStages(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_sck_i     (sck),
    .spi_mosi_i    (mosi),
    .spi_cs_ni     (cs_n),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (oe),
    .reg_we_i      (we),
    .reg_addr_i    (raddr),
    .reg_wdata_i   (wdata),
    .reg_rdata_o   (rdata),
    .spi_wr_o      (wr),
    .spi_wr_addr_o (wr_addr),
    .spi_wr_data_o (wr_data),
    .busy_o        (busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          wr_seen = 0;
  bit          hold_addr = 1'b0;
  logic [7:0]  mem [64];
  logic [13:0] exp_wr [$];
  logic [7:0]  exp_rd [8];
  logic [7:0]  tx_b [8];
  logic [7:0]  rx_b [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [5:0] a);
    return (a == 6'h00) ? 8'hE5 : mem[a];
  endfunction

  task automatic do_compare();
    logic [13:0] e;
    if (wr === 1'b1) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 32'(wr), 32'(0));
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[13:8]));
        chk("wr_data", 32'(wr_data), 32'(e[7:0]));
        mem[e[13:8]] = e[7:0];
      end
    end
    chk("rdata", 32'(rdata), 32'(mem[raddr]));
  endtask

  task automatic cyc();
    @(negedge clk);
    do_compare();
    @(posedge clk);
    #1;
    if (!we && !hold_addr) raddr = 6'($urandom_range(1, 63));
  endtask

  task automatic local_wr(input logic [5:0] a, input logic [7:0] d);
    we = 1'b1; raddr = a; wdata = d;
    cyc();
    we = 1'b0;
    if (a != 6'h00) mem[a] = d;
  endtask

  task automatic local_rd(input string name, input logic [5:0] a, input logic [7:0] lit);
    hold_addr = 1'b1; raddr = a;
    cyc();
    chk(name, 32'(rdata), 32'(lit));
    hold_addr = 1'b0;
  endtask

  task automatic spi_xfer(input int nbits, input int coll_bit,
                          input logic [5:0] coll_addr, input logic [7:0] coll_data);
    cs_n = 1'b0;
    repeat (CsSetup) cyc();
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = tx_b[i / 8][7 - (i % 8)];
      repeat (Half) cyc();
      rx_b[i / 8][7 - (i % 8)] = miso;
      sck = 1'b1;
      if (i == coll_bit) begin
        // Land the local write on the same clock as the SPI commit.
        cyc(); cyc();
        we = 1'b1; raddr = coll_addr; wdata = coll_data;
        cyc();
        we = 1'b0;
        repeat (Half - 3) cyc();
      end else begin
        repeat (Half) cyc();
      end
    end
    repeat (Half) cyc();
    cs_n = 1'b1;
    repeat (CsHold) cyc();
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int ndata, input int partial,
                         input bit preset, input int coll_bit,
                         input logic [5:0] coll_addr, input logic [7:0] coll_data);
    logic [5:0] a;
    int nfull;
    a = cmd[5:0];
    tx_b[0] = cmd;
    nfull = (partial > 0) ? ndata - 1 : ndata;
    if (!preset) for (int j = 0; j < ndata; j++) tx_b[j + 1] = 8'($urandom);
    for (int j = 0; j < nfull; j++) begin
      if (cmd[7]) exp_rd[j] = m_rd(a);
      else if (a != 6'h00) exp_wr.push_back({a, tx_b[j + 1]});
      if (cmd[6]) a = a + 6'd1;
    end
    spi_xfer(8 + 8 * nfull + partial, coll_bit, coll_addr, coll_data);
    if (cmd[7]) for (int j = 0; j < nfull; j++) chk("rd_byte", 32'(rx_b[j + 1]), 32'(exp_rd[j]));
    chk("wr_pending", 32'(exp_wr.size()), 32'(0));
    chk("busy_end", 32'(busy), 32'(0));
    chk("oe_end", 32'(oe), 32'(0));
    chk("miso_end", 32'(miso), 32'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, nl, nd, part;
    logic [7:0] cmd;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_oe", 32'(oe), 32'(0));
    chk("rst_miso", 32'(miso), 32'(0));
    chk("rst_wr", 32'(wr), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    local_rd("rst_reg3f", 6'h3F, 8'h00);

    // Device ID read
    run_txn(8'h80, 1, 0, 1'b0, -1, 6'h00, 8'h00);
    chk("devid", 32'(rx_b[1]), 32'(8'hE5));

    // Auto-increment write burst
    base = wr_seen;
    tx_b[1] = 8'h11; tx_b[2] = 8'h22;
    run_txn(8'h72, 2, 0, 1'b1, -1, 6'h00, 8'h00);
    local_rd("burst_32", 6'h32, 8'h11);
    local_rd("burst_33", 6'h33, 8'h22);
    chk("burst_pulses", 32'(wr_seen - base), 32'(2));

    // Local writes read back over SPI, with and without auto-increment
    local_wr(6'h32, 8'hA5);
    local_wr(6'h33, 8'h5A);
    run_txn(8'hF2, 2, 0, 1'b0, -1, 6'h00, 8'h00);
    chk("mb_rd0", 32'(rx_b[1]), 32'(8'hA5));
    chk("mb_rd1", 32'(rx_b[2]), 32'(8'h5A));
    run_txn(8'hB2, 2, 0, 1'b0, -1, 6'h00, 8'h00);
    chk("nomb_rd0", 32'(rx_b[1]), 32'(8'hA5));
    chk("nomb_rd1", 32'(rx_b[2]), 32'(8'hA5));

    // Address wrap into the read-only ID register
    base = wr_seen;
    tx_b[1] = 8'h3C; tx_b[2] = 8'h99;
    run_txn(8'h7F, 2, 0, 1'b1, -1, 6'h00, 8'h00);
    chk("wrap_pulses", 32'(wr_seen - base), 32'(1));
    local_rd("wrap_3f", 6'h3F, 8'h3C);
    run_txn(8'h80, 1, 0, 1'b0, -1, 6'h00, 8'h00);
    chk("wrap_devid", 32'(rx_b[1]), 32'(8'hE5));
    local_wr(6'h00, 8'h12);
    run_txn(8'h80, 1, 0, 1'b0, -1, 6'h00, 8'h00);
    chk("local0_devid", 32'(rx_b[1]), 32'(8'hE5));

    // Abort after 5 data bits
    local_wr(6'h10, 8'h77);
    base = wr_seen;
    run_txn(8'h10, 1, 5, 1'b0, -1, 6'h00, 8'h00);
    chk("abort_pulses", 32'(wr_seen - base), 32'(0));
    local_rd("abort_10", 6'h10, 8'h77);

    // Same-address collision: SPI commit wins
    tx_b[1] = 8'hCC;
    run_txn(8'h20, 1, 0, 1'b1, 15, 6'h20, 8'h33);
    local_rd("collide_20", 6'h20, 8'hCC);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      nl = $urandom_range(0, 2);
      for (int k = 0; k < nl; k++) local_wr(6'($urandom_range(0, 63)), 8'($urandom));
      cmd  = 8'($urandom);
      nd   = $urandom_range(1, 3);
      part = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      run_txn(cmd, nd, part, 1'b0, -1, 6'h00, 8'h00);
    end

    // Reset in the middle of a read
    cs_n = 1'b0;
    repeat (CsSetup) cyc();
    tx_b[0] = 8'h80;
    for (int i = 0; i < 11; i++) begin
      sck  = 1'b0;
      mosi = (i < 8) ? tx_b[0][7 - i] : 1'b0;
      repeat (Half) cyc();
      sck = 1'b1;
      repeat (Half) cyc();
    end
    chk("mid_busy", 32'(busy), 32'(1));
    chk("mid_oe", 32'(oe), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_oe", 32'(oe), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_miso", 32'(miso), 32'(0));
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    exp_wr.delete();
    cs_n = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    local_rd("rst_clear_32", 6'h32, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
